// File: rtl/decimal_in_hex.sv
// Registered single-digit 7-segment decoder (active-low, bit0=a..bit6=g) with
// error dash, forced blank and ripple-blank leading-zero suppression.
// Optional: define DECIMAL_IN_HEX_HEX_DIGITS_EN to show 10..15 as A..F.
module decimal_in_hex (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] num,
    input  logic        blank,
    input  logic        rbi,
    output logic [6:0]  HEX,
    output logic        err,
    output logic        rbo
);

`ifdef DECIMAL_IN_HEX_HEX_DIGITS_EN
    localparam logic [31:0] MAX_NUM = 32'd15;
`else
    localparam logic [31:0] MAX_NUM = 32'd9;
`endif

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic [6:0] hex_q;
    logic [6:0] hex_d;
    logic       err_q;
    logic       err_d;
    logic [6:0] seg;

    // Zero suppression ripples through the whole chain combinationally.
    assign rbo = rbi && (num == 32'd0);

    always_comb begin
        seg = SEG_DASH;
        case (num[3:0])
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
`ifdef DECIMAL_IN_HEX_HEX_DIGITS_EN
            4'd10:   seg = 7'h08;
            4'd11:   seg = 7'h03;
            4'd12:   seg = 7'h46;
            4'd13:   seg = 7'h21;
            4'd14:   seg = 7'h06;
            4'd15:   seg = 7'h0E;
`endif
            default: seg = SEG_DASH;
        endcase
    end

    // Range test covers all 32 bits, so e.g. 0x103 is an error, never digit 3.
    always_comb begin
        hex_d = SEG_OFF;
        err_d = 1'b0;
        if (blank) begin
            hex_d = SEG_OFF;
            err_d = 1'b0;
        end else if (num > MAX_NUM) begin
            hex_d = SEG_DASH;
            err_d = 1'b1;
        end else if (rbi && (num == 32'd0)) begin
            hex_d = SEG_OFF;
            err_d = 1'b0;
        end else begin
            hex_d = seg;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q <= SEG_OFF;
            err_q <= 1'b0;
        end else begin
            hex_q <= hex_d;
            err_q <= err_d;
        end
    end

    assign HEX = hex_q;
    assign err = err_q;

endmodule

// File: tb/tb_decimal_in_hex.sv
// Randomised bench for decimal_in_hex: one standalone digit plus a three-digit
// score chain, checked every cycle against a table-driven reference model.
module tb_decimal_in_hex;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] num = 32'd0;
    logic        blank = 1'b0;
    logic        rbi = 1'b0;
    logic [6:0]  HEX;
    logic        err;
    logic        rbo;

    int          score = 0;
    logic [31:0] h_num, t_num, o_num;
    logic [6:0]  h_hex, t_hex, o_hex;
    logic        h_err, t_err, o_err;
    logic        h_rbo, t_rbo, o_rbo;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    logic [7:0] exp_s, exp_h, exp_t, exp_o;

    always #5 clk = ~clk;

    assign h_num = 32'(score / 100);
    assign t_num = 32'((score / 10) % 10);
    assign o_num = 32'(score % 10);

    decimal_in_hex u_dut (
        .clk(clk), .reset(reset), .num(num), .blank(blank), .rbi(rbi),
        .HEX(HEX), .err(err), .rbo(rbo)
    );
    decimal_in_hex u_hund (
        .clk(clk), .reset(reset), .num(h_num), .blank(1'b0), .rbi(1'b1),
        .HEX(h_hex), .err(h_err), .rbo(h_rbo)
    );
    decimal_in_hex u_tens (
        .clk(clk), .reset(reset), .num(t_num), .blank(1'b0), .rbi(h_rbo),
        .HEX(t_hex), .err(t_err), .rbo(t_rbo)
    );
    decimal_in_hex u_ones (
        .clk(clk), .reset(reset), .num(o_num), .blank(1'b0), .rbi(1'b0),
        .HEX(o_hex), .err(o_err), .rbo(o_rbo)
    );

    // Reference: {err, HEX} from the priority rules and a glyph table.
    function automatic logic [7:0] model(input logic [31:0] n, input logic b, input logic r);
        logic [6:0] glyph [16];
        int limit;
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef DECIMAL_IN_HEX_HEX_DIGITS_EN
        limit = 15;
`else
        limit = 9;
`endif
        if (b) return {1'b0, 7'h7F};
        if (n > 32'(limit)) return {1'b1, 7'h3F};
        if (r && n == 0) return {1'b0, 7'h7F};
        return {1'b0, glyph[n]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    endtask

    // Inputs change 3 time units after a rising edge; returns 3 units after the next one.
    task automatic drive(input logic [31:0] n, input logic b, input logic r);
        num = n; blank = b; rbi = r;
        @(posedge clk); #3;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_s <= {1'b0, 7'h7F};
            exp_h <= {1'b0, 7'h7F};
            exp_t <= {1'b0, 7'h7F};
            exp_o <= {1'b0, 7'h7F};
        end else begin
            exp_s <= model(num, blank, rbi);
            exp_h <= model(32'(score / 100), 1'b0, 1'b1);
            exp_t <= model(32'((score / 10) % 10), 1'b0, score < 100);
            exp_o <= model(32'(score % 10), 1'b0, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("single", {err, HEX}, exp_s);
            chk("hund",   {h_err, h_hex}, exp_h);
            chk("tens",   {t_err, t_hex}, exp_t);
            chk("ones",   {o_err, o_hex}, exp_o);
            chk("rbo",    rbo, rbi && num == 0);
            chk("hund_rbo", h_rbo, score < 100);
        end
    end

    initial begin
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        chk("reset_hex", HEX, 7'h7F);
        chk("reset_err", err, 1'b0);
        @(posedge clk); @(posedge clk); #3;
        num = 32'd5; reset = 1'b0;
        @(posedge clk); #3;
        chk("post_reset_5", HEX, 7'h12);

        // Asynchronous reset mid-cycle with an error pending.
        drive(32'd12, 1'b0, 1'b0);
        chk("pre_reset_err", err, 1'b1);
        num = 32'd5; reset = 1'b1; #1;
        chk("async_reset_hex", HEX, 7'h7F);
        chk("async_reset_err", err, 1'b0);
        #1 reset = 1'b0;
        @(posedge clk); #3;
        chk("release_5", HEX, 7'h12);

        // Digit sweep.
        for (int d = 0; d < 10; d++) begin
            drive(32'(d), 1'b0, 1'b0);
            if (d == 9) chk("digit9", HEX, 7'h10);
            if (d == 1) chk("digit1", HEX, 7'h79);
        end

`ifdef DECIMAL_IN_HEX_HEX_DIGITS_EN
        drive(32'd10, 1'b0, 1'b0);
        chk("num10", {err, HEX}, {1'b0, 7'h08});
`else
        drive(32'd10, 1'b0, 1'b0);
        chk("num10", {err, HEX}, {1'b1, 7'h3F});
`endif
        drive(32'd999, 1'b0, 1'b0);
        chk("num999", {err, HEX}, {1'b1, 7'h3F});
        drive(32'h0000_0103, 1'b0, 1'b0);
        chk("num103", {err, HEX}, {1'b1, 7'h3F});

        // Ripple-blank output is combinational.
        num = 32'd0; rbi = 1'b1; #1;
        chk("rbo_zero", rbo, 1'b1);
        num = 32'd3; #1;
        chk("rbo_three", rbo, 1'b0);
        @(posedge clk); #3;

        // Blank has top priority, then the range error.
        drive(32'd12, 1'b1, 1'b0);
        chk("blank12", {err, HEX}, {1'b0, 7'h7F});
        drive(32'd12, 1'b0, 1'b0);
`ifndef DECIMAL_IN_HEX_HEX_DIGITS_EN
        chk("unblank12", {err, HEX}, {1'b1, 7'h3F});
`endif

        // Leading-zero chain.
        score = 1;   drive(32'd0, 1'b0, 1'b0);
        chk("s1", {h_hex, t_hex, o_hex}, {7'h7F, 7'h7F, 7'h79});
        score = 10;  drive(32'd0, 1'b0, 1'b0);
        chk("s10", {h_hex, t_hex, o_hex}, {7'h7F, 7'h79, 7'h40});
        score = 100; drive(32'd0, 1'b0, 1'b0);
        chk("s100", {h_hex, t_hex, o_hex}, {7'h79, 7'h40, 7'h40});

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            int sel;
            logic [31:0] n;
            sel = $urandom_range(0, 3);
            if (sel < 2)       n = 32'($urandom_range(0, 9));
            else if (sel == 2) n = 32'($urandom_range(0, 20));
            else               n = $urandom;
            if ($urandom_range(0, 3) == 0) n = 32'd0;
            score = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 999))
                                                : int'($urandom_range(0, 120));
            drive(n, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decimal_in_hex.md
Name: decimal_in_hex

Overview:
- Registered single-digit decoder: converts an unsigned binary value into an active-low 7-segment pattern for one DE1-SoC HEX display.
- Instantiated once per decimal digit by the score display. Typical wiring: hundreds gets score/100, tens gets score/10%10, ones gets score%10.
- Adds out-of-range indication, forced blanking, and leading-zero suppression via a ripple-blank chain.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- num  input  32  unsigned value to display (full-width quotient/remainder from the caller)
- blank  input  1  force display dark
- rbi  input  1  ripple-blank-in: suppress a zero on this digit (tie 0 for the ones digit)
- HEX  output  7  registered segment pattern, active-low, bit0=a … bit6=g
- err  output  1  registered: num not displayable
- rbo  output  1  combinational ripple-blank-out, feeds the next lower digit's rbi

Behaviour:
- Single clock domain, no handshake. HEX and err update one clock after inputs change (latency 1).
- Reset is asynchronous: on assertion, HEX=7'h7F (all off) and err=0 immediately, held while reset is high.
- First edge after reset release loads the decode of the current inputs.
- rbo = rbi AND (num==0).
  - Purely combinational and not affected by reset or blank.
  - A whole chain resolves within one cycle.
- Decode priority, evaluated each edge, highest first:
  1. blank=1 -> HEX=7'h7F, err=0.
  2. num out of range -> HEX=7'h3F (dash, g only), err=1. Out of range means num>9, or num>15 with HEX_DIGITS_EN.
  3. rbi=1 and num==0 -> HEX=7'h7F, err=0.
  4. Otherwise, digit pattern with err=0:
     - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
     - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
- Range compare uses all 32 bits.
  - e.g. num=32'h0000_0103 is out of range, not the digit 3.
  - No truncation or modulo inside the block.
- HEX and err hold their value between edges. No glitches on the outputs since both are flops.
- Reset asserted mid-operation overrides any pending decode.

Optional Feature:
- Macro DECIMAL_IN_HEX_HEX_DIGITS_EN.
- When defined:
  - num 10..15 display A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E, with err=0.
  - Only num>15 gives the dash and err=1.
- When undefined: any num>9 gives the dash and err=1.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with num=5 -> HEX=7'h7F and err=0 before the next edge. Release, then one edge -> HEX=7'h12.
- Digit sweep: rbi=0, blank=0, num=0..9 on successive cycles -> HEX follows the table one cycle later (e.g. num=9 -> 7'h10, num=1 -> 7'h79), err=0 throughout.
- Range: num=10 -> HEX=7'h3F, err=1 (macro off), or HEX=7'h08, err=0 (macro on). num=999 -> HEX=7'h3F, err=1 in both builds.
- Leading-zero chain: three instances (hundreds rbi=1, tens rbi fed from hundreds rbo, ones rbi=0):
  - score=1 -> hundreds/tens 7'h7F, ones 7'h79.
  - score=10 -> hundreds 7'h7F, tens 7'h79, ones 7'h40.
  - score=100 -> 7'h79 / 7'h40 / 7'h40.
- Ripple-blank output: rbi=1, num=0 -> rbo=1 in the same cycle. Then num=3 with rbi=1 -> rbo=0.
- Priority: blank=1 with num=12 -> HEX=7'h7F, err=0. Drop blank -> next edge HEX=7'h3F, err=1 (macro off).
